// File: rtl/mpu6050_read_seq.sv
// MPU6050 transaction sequencer.
// Drives the I2C master-config engine: after the power-up delay it writes the
// wake and range registers, then once per sample period reads the 14
// measurement bytes 0x3B..0x48 one transaction at a time and publishes them as
// seven signed 16-bit words with a one-cycle data_valid strobe.
module mpu6050_read_seq #(
  parameter logic [6:0]  DEV_ADDR    = 7'h68,
  parameter int unsigned POWERUP_DLY = 1200000,
  parameter int unsigned SAMPLE_DIV  = 120000,
  parameter int unsigned TIMEOUT     = 24000,
  parameter int unsigned BACKOFF     = 12000
) (
  input  logic               sys_clk_12m,
  input  logic               rst,
  output logic [6:0]         i2c_dev_addr,
  output logic [7:0]         i2c_reg_addr,
  output logic [7:0]         i2c_reg_data,
  output logic [7:0]         i2c_config,
  input  logic               i2c_done,
  input  logic [7:0]         i2c_ack,
  input  logic [7:0]         i2c_read_data,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic signed [15:0] temp_raw,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               data_valid,
  output logic               init_done,
  output logic               err_pulse,
  output logic [7:0]         err_cnt
);

  // One shared timer covers the power-up delay, the per-transaction timeout
  // and the error back-off, so it must hold the largest of the three.
  localparam int unsigned TMAX = (POWERUP_DLY > TIMEOUT) ?
                                 ((POWERUP_DLY > BACKOFF) ? POWERUP_DLY : BACKOFF) :
                                 ((TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF);
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam int unsigned SW = $clog2(SAMPLE_DIV + 1);

  localparam logic [7:0] CFG_WR   = 8'h01;
  localparam logic [7:0] CFG_RD   = 8'h03;
  localparam logic [7:0] CFG_IDLE = 8'h00;
  localparam logic [7:0] RD_BASE  = 8'h3B;
  localparam logic [3:0] LAST_IDX = 4'd13;
  localparam logic [1:0] LAST_STEP = 2'd2;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_REQ,
    INIT_WAIT,
    PERIOD_WAIT,
    RD_REQ,
    RD_WAIT,
    PUBLISH,
    BACKOFF_ST
  } state_t;

  state_t         state;
  logic [1:0]     step;
  logic [3:0]     idx;
  logic [TW-1:0]  tmr;
  logic [SW-1:0]  pcnt;
  logic           init_err;
  logic [7:0]     byte_buf [0:13];

  logic           in_wait;
  logic           xfer_ok;
  logic           xfer_err;
  logic           period_wrap;

  // Register written by each init step: PWR_MGMT_1, GYRO_CONFIG, ACCEL_CONFIG.
  function automatic logic [7:0] init_addr(input logic [1:0] s);
    case (s)
      2'd0:    init_addr = 8'h6B;
      2'd1:    init_addr = 8'h1B;
      default: init_addr = 8'h1C;
    endcase
  endfunction

  // Measurement register for byte index i of a burst.
  function automatic logic [7:0] rd_addr(input logic [3:0] i);
    rd_addr = RD_BASE + {4'h0, i};
  endfunction

  // The sensor sends each word high byte first.
  function automatic logic signed [15:0] pack_word(input logic [7:0] hi,
                                                  input logic [7:0] lo);
    pack_word = signed'({hi, lo});
  endfunction

  // Error counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign i2c_dev_addr = DEV_ADDR;

  // Transaction outcome, only meaningful while waiting on the engine; a done
  // pulse seen in any other state is ignored.
  always_comb begin
    in_wait     = (state == INIT_WAIT) || (state == RD_WAIT);
    xfer_ok     = in_wait && i2c_done && (i2c_ack == 8'h00);
    xfer_err    = in_wait && ((i2c_done && (i2c_ack != 8'h00)) ||
                              (!i2c_done && (tmr == TW'(TIMEOUT - 1))));
    period_wrap = (pcnt == SW'(SAMPLE_DIV - 1));
  end

  // Capture read bytes; the buffer is pure data and needs no reset because a
  // burst is only published after all 14 bytes have been rewritten.
  always_ff @(posedge sys_clk_12m) begin
    if ((state == RD_WAIT) && xfer_ok) begin
      byte_buf[idx] <= i2c_read_data;
    end
  end

  // Sequencer FSM with registered engine controls, samples and status.
  always_ff @(posedge sys_clk_12m or posedge rst) begin
    if (rst) begin
      state        <= PWRUP;
      step         <= 2'd0;
      idx          <= 4'd0;
      tmr          <= '0;
      pcnt         <= '0;
      init_err     <= 1'b0;
      i2c_reg_addr <= 8'h00;
      i2c_reg_data <= 8'h00;
      i2c_config   <= CFG_IDLE;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      temp_raw     <= '0;
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
      data_valid   <= 1'b0;
      init_done    <= 1'b0;
      err_pulse    <= 1'b0;
      err_cnt      <= 8'h00;
    end else begin
      data_valid <= 1'b0;
      err_pulse  <= 1'b0;

      // Sample period counter free-runs once init is complete, so burst
      // starts stay on a fixed grid regardless of burst length or errors.
      if (init_done) begin
        pcnt <= period_wrap ? '0 : pcnt + 1'b1;
      end

      if (xfer_err) begin
        err_pulse  <= 1'b1;
        err_cnt    <= sat_inc(err_cnt);
        i2c_config <= CFG_IDLE;
        init_err   <= (state == INIT_WAIT);
        tmr        <= '0;
        state      <= BACKOFF_ST;
      end else begin
        case (state)
          PWRUP: begin
            if (tmr == TW'(POWERUP_DLY - 1)) begin
              tmr   <= '0;
              step  <= 2'd0;
              state <= INIT_REQ;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end

          INIT_REQ: begin
            i2c_reg_addr <= init_addr(step);
            i2c_reg_data <= 8'h00;
            i2c_config   <= CFG_WR;
            tmr          <= '0;
            state        <= INIT_WAIT;
          end

          INIT_WAIT: begin
            if (i2c_done) begin
              i2c_config <= CFG_IDLE;
              if (step == LAST_STEP) begin
                init_done <= 1'b1;
                pcnt      <= '0;
                state     <= PERIOD_WAIT;
              end else begin
                step  <= step + 2'd1;
                state <= INIT_REQ;
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end

          PERIOD_WAIT: begin
            if (period_wrap) begin
              idx   <= 4'd0;
              state <= RD_REQ;
            end
          end

          RD_REQ: begin
            i2c_reg_addr <= rd_addr(idx);
            i2c_config   <= CFG_RD;
            tmr          <= '0;
            state        <= RD_WAIT;
          end

          RD_WAIT: begin
            if (i2c_done) begin
              i2c_config <= CFG_IDLE;
              if (idx == LAST_IDX) begin
                // Last byte comes straight from the engine so the words and
                // the strobe land one cycle after the final done.
                accel_x    <= pack_word(byte_buf[0],  byte_buf[1]);
                accel_y    <= pack_word(byte_buf[2],  byte_buf[3]);
                accel_z    <= pack_word(byte_buf[4],  byte_buf[5]);
                temp_raw   <= pack_word(byte_buf[6],  byte_buf[7]);
                gyro_x     <= pack_word(byte_buf[8],  byte_buf[9]);
                gyro_y     <= pack_word(byte_buf[10], byte_buf[11]);
                gyro_z     <= pack_word(byte_buf[12], i2c_read_data);
                data_valid <= 1'b1;
                state      <= PUBLISH;
              end else begin
                idx   <= idx + 4'd1;
                state <= RD_REQ;
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end

          PUBLISH: begin
            state <= PERIOD_WAIT;
          end

          BACKOFF_ST: begin
            if (tmr == TW'(BACKOFF - 1)) begin
              tmr <= '0;
              if (init_err) begin
                step  <= 2'd0;
                state <= INIT_REQ;
              end else begin
                idx   <= 4'd0;
                state <= RD_REQ;
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end

          default: begin
            state <= PWRUP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_read_seq.sv
// Bench for mpu6050_read_seq: an I2C engine model that answers requests after
// 8 cycles with random or patterned bytes, a reference model that forms the
// expected words from the bytes actually served, and a directed sequence for
// init, period, NACK, timeout, saturation and mid-burst reset.
`timescale 1ns/1ps
module tb_mpu6050_read_seq;

  localparam int PD = 10;
  localparam int SD = 400;
  localparam int TO = 50;
  localparam int BO = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_reg_data;
  logic [7:0]  i2c_config;
  logic        i2c_done = 1'b0;
  logic [7:0]  i2c_ack = 8'h00;
  logic [7:0]  i2c_read_data = 8'h00;
  logic signed [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;
  logic        data_valid;
  logic        init_done;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [111:0] outs;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mpu6050_read_seq #(
    .DEV_ADDR(7'h68), .POWERUP_DLY(PD), .SAMPLE_DIV(SD), .TIMEOUT(TO), .BACKOFF(BO)
  ) dut (
    .sys_clk_12m(clk), .rst(rst),
    .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_reg_data(i2c_reg_data), .i2c_config(i2c_config),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack), .i2c_read_data(i2c_read_data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp_raw(temp_raw),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .data_valid(data_valid), .init_done(init_done),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  assign outs = {accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- engine model ----------------
  int         mode = 1;            // 0 random, 1 bytes 0x01..0x0E, 2 negative accel_x
  logic [7:0] nack_reg = 8'h00;    // NACK any request to this register
  logic [7:0] hold_reg = 8'h00;    // withhold done for this register
  bit         nack_all = 1'b0;
  logic [7:0] served [14];
  logic [7:0] req_addr_q [$];
  logic [7:0] req_cfg_q  [$];
  logic [7:0] req_data_q [$];
  bit         busy = 1'b0, armed = 1'b0, withhold = 1'b0, nack_now = 1'b0, prev_nack = 1'b0;
  int         ecnt = 0;
  logic [7:0] l_addr = 8'h00, l_cfg = 8'h00, l_data = 8'h00;
  int         cfg_hold_viol = 0;
  int         last_done_cyc = 0, norm_gap = -1, err_gap = -1, wh_req_cyc = 0;
  int         prev_3b = 0, last_3b = 0;

  function automatic logic [7:0] gen_byte(input logic [7:0] a);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (mode == 1) b = a - 8'h3A;
    else if (mode == 2 && a == 8'h3B) b = 8'hFF;
    else if (mode == 2 && a == 8'h3C) b = 8'h38;
    return b;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_ack  = 8'h00;
      if (rst) begin
        busy = 1'b0; withhold = 1'b0; prev_nack = 1'b0;
      end else if (busy) begin
        ecnt++;
        if (withhold) begin
          if (!i2c_config[0]) begin busy = 1'b0; withhold = 1'b0; end
        end else begin
          if (i2c_config !== l_cfg || i2c_reg_addr !== l_addr || i2c_reg_data !== l_data)
            cfg_hold_viol++;
          if (ecnt == 8) begin
            i2c_done = 1'b1; busy = 1'b0; armed = 1'b0; last_done_cyc = cyc;
            if (nack_now) begin
              i2c_ack = 8'h01; i2c_read_data = 8'($urandom_range(0, 255)); prev_nack = 1'b1;
            end else if (l_cfg[1]) begin
              i2c_read_data = gen_byte(l_addr);
              if (l_addr >= 8'h3B && l_addr <= 8'h48) served[int'(l_addr) - 59] = i2c_read_data;
            end
          end
        end
      end else if (i2c_config[0] && armed) begin
        busy = 1'b1; ecnt = 0;
        l_addr = i2c_reg_addr; l_cfg = i2c_config; l_data = i2c_reg_data;
        req_addr_q.push_back(l_addr); req_cfg_q.push_back(l_cfg); req_data_q.push_back(l_data);
        if (prev_nack) err_gap = cyc - last_done_cyc;
        else if (l_addr != 8'h3B) norm_gap = cyc - last_done_cyc;
        prev_nack = 1'b0;
        withhold = (hold_reg != 8'h00) && (l_addr == hold_reg);
        if (withhold) wh_req_cyc = cyc;
        nack_now = nack_all || ((nack_reg != 8'h00) && (l_addr == nack_reg));
        if (l_addr == 8'h3B) begin prev_3b = last_3b; last_3b = cyc; end
      end
      if (!i2c_config[0]) armed = 1'b1;
    end
  end

  // ---------------- output monitor / reference model ----------------
  logic [111:0] last_pub = '0;
  int dv_count = 0, err_seen = 0, err_cyc = 0, held_viol = 0;

  initial begin
    logic [111:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_pub = '0;
      end else begin
        if (data_valid) begin
          for (int k = 0; k < 7; k++)
            e[111 - 16*k -: 16] = 16'(int'(served[2*k]) * 256 + int'(served[2*k+1]));
          for (int k = 0; k < 7; k++)
            chk($sformatf("word%0d", k), {16'h0, outs[111 - 16*k -: 16]}, {16'h0, e[111 - 16*k -: 16]});
          chk("dv_latency", cyc, last_done_cyc + 1);
          last_pub = e;
          dv_count++;
        end else if (outs !== last_pub) begin
          held_viol++;
        end
        if (err_pulse) begin err_seen++; err_cyc = cyc; end
      end
    end
  end

  task automatic wait_dv(input string tag, input int bound);
    int start, k;
    start = dv_count; k = 0;
    while (dv_count == start && k < bound) begin @(negedge clk); #1; k++; end
    chk(tag, dv_count - start, 1);
  endtask

  task automatic wait_err(input string tag, input int bound);
    int start, k;
    start = err_seen; k = 0;
    while (err_seen == start && k < bound) begin @(negedge clk); #1; k++; end
    chk(tag, err_seen - start, 1);
  endtask

  task automatic wait_init(input string tag, input int bound);
    int k;
    k = 0;
    while (!init_done && k < bound) begin @(negedge clk); #1; k++; end
    chk(tag, init_done, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, hv, es, dvs;
    logic [7:0] exp_init [3];
    logic [7:0] exp_re [5];
    exp_init[0] = 8'h6B; exp_init[1] = 8'h1B; exp_init[2] = 8'h1C;
    exp_re[0] = 8'h6B; exp_re[1] = 8'h1B; exp_re[2] = 8'h6B; exp_re[3] = 8'h1B; exp_re[4] = 8'h1C;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg", i2c_config, 8'h00);
    chk("rst_reg_addr", i2c_reg_addr, 8'h00);
    chk("rst_reg_data", i2c_reg_data, 8'h00);
    chk("rst_dev_addr", i2c_dev_addr, 7'h68);
    chk("rst_samples_zero", (outs == '0), 1);
    chk("rst_flags", {data_valid, init_done, err_pulse}, 3'b000);
    chk("rst_err_cnt", err_cnt, 8'h00);
    rst = 1'b0;

    // Init writes
    wait_init("init_done", 1000);
    chk("init_txn_count", req_addr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("init_addr%0d", i), req_addr_q[i], exp_init[i]);
      chk($sformatf("init_data%0d", i), req_data_q[i], 8'h00);
      chk($sformatf("init_cfg%0d", i), req_cfg_q[i], 8'h01);
    end
    req_addr_q.delete(); req_cfg_q.delete(); req_data_q.delete();

    // Patterned burst 0x01..0x0E
    wait_dv("dv_seq", 1500);
    chk("rd_txn_count", req_addr_q.size(), 14);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("rd_addr%0d", i), req_addr_q[i], 8'(8'h3B + i));
      chk($sformatf("rd_cfg%0d", i), req_cfg_q[i], 8'h03);
    end
    chk("ax_seq", {16'h0, accel_x}, 32'h0102);
    chk("temp_seq", {16'h0, temp_raw}, 32'h0708);
    chk("gz_seq", {16'h0, gyro_z}, 32'h0D0E);

    // Negative accel_x and burst spacing
    mode = 2;
    wait_dv("dv_neg_a", 1000);
    chk("ax_neg", {16'h0, accel_x}, 32'hFF38);
    chk("ax_neg_signed", (accel_x == -16'sd200), 1);
    wait_dv("dv_neg_b", 1000);
    chk("burst_period", last_3b - prev_3b, SD);
    mode = 0;
    wait_dv("dv_rand", 1000);

    // NACK on read idx 5
    hv = held_viol;
    nack_reg = 8'h40;
    wait_err("nack_err", 1000);
    nack_reg = 8'h00;
    chk("nack_err_cnt", err_cnt, 8'd1);
    k = 0;
    while (prev_nack && k < 100) begin @(negedge clk); #1; k++; end
    chk("retry_addr", l_addr, 8'h3B);
    chk("backoff_gap", err_gap, norm_gap + BO);
    wait_dv("dv_after_nack", 1000);
    chk("held_outputs", held_viol - hv, 0);

    // Reset during read idx 7, then withheld done on init step 1
    hold_reg = 8'h1B;
    k = 0;
    while (!(busy && l_addr == 8'h42) && k < 1000) begin @(negedge clk); #1; k++; end
    chk("reached_idx7", l_addr, 8'h42);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_cfg", i2c_config, 8'h00);
    chk("arst_samples_zero", (outs == '0), 1);
    chk("arst_flags", {data_valid, init_done, err_pulse}, 3'b000);
    chk("arst_err_cnt", err_cnt, 8'h00);
    repeat (3) @(negedge clk);
    req_addr_q.delete(); req_cfg_q.delete(); req_data_q.delete();
    #1 rst = 1'b0;
    wait_err("timeout_err", 1000);
    hold_reg = 8'h00;
    chk("timeout_latency", err_cyc - wh_req_cyc, TO);
    wait_init("reinit_done", 1000);
    chk("reinit_txn_count", req_addr_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("reinit_addr%0d", i), req_addr_q[i], exp_re[i]);
    chk("reinit_err_cnt", err_cnt, 8'd1);

    // Error counter saturation
    es = err_seen; dvs = dv_count;
    nack_all = 1'b1;
    k = 0;
    while (err_seen - es < 260 && k < 20000) begin @(negedge clk); #1; k++; end
    chk("sat_err_pulses", (err_seen - es >= 260), 1);
    chk("err_cnt_sat", err_cnt, 8'd255);
    chk("init_done_held", init_done, 1);
    chk("no_dv_during_errs", dv_count - dvs, 0);
    nack_all = 1'b0;
    chk("cfg_hold", cfg_hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
